if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] are zero.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  fetch address, equal to the current PC.
REQ-006 imem_ready  in  1  imem_rdata is valid this cycle for imem_addr.
REQ-007 imem_rdata  in  32  instruction word.
REQ-008 stall  in  1  hazard stall: hold PC and the IF/ID register.
REQ-009 flush  in  1  kill the instruction entering IF/ID.
REQ-010 redirect  in  1  taken branch or jump.
REQ-011 redirect_pc  in  32  target address; bits [1:0] are forced to 00.
REQ-012 id_valid  out  1  the IF/ID register holds a real instruction.
REQ-013 id_pc, id_pc_plus4  out  32 each  address of the held instruction, and that address plus 4.
REQ-014 id_opcode [31:26], id_rs [25:21], id_rt [20:16], id_rd [15:11], id_funct [5:0], id_imm [15:0]  out  6/5/5/5/6/16  fields of the held instruction.

Function
REQ-015 Control FSM has two states:
- BOOT: entered on reset; imem_req=0; moves to RUN after exactly one clock.
- RUN: imem_req=1 unless stall=1.
REQ-016 RUN accept condition: imem_ready=1, stall=0, flush=0, redirect=0. On accept, all in the same edge:
- PC <= PC+4;
- IF/ID <= {imem_rdata fields, PC, PC+4};
- id_valid <= 1.
REQ-017 RUN, imem_ready=0, stall=0: PC holds; id_valid <= 0 (bubble).
REQ-018 stall=1 (no redirect, no flush): PC, id_valid and all IF/ID fields hold.
REQ-019 flush=1 (no redirect): id_valid <= 0 and the fields go to the bubble value; PC holds.
REQ-020 redirect=1 in RUN:
- PC <= {redirect_pc[31:2],2'b00};
- id_valid <= 0 and the fields go to the bubble value;
- applies regardless of stall, flush and imem_ready.
REQ-021 Priority: redirect > flush > stall > imem_ready.
REQ-022 Redirect in BOOT: ignored; PC stays RESET_PC.
REQ-023 Bubble value: all id_* fields zero (opcode 0, funct 0). This decodes as no register write, memory write, branch or jump.
REQ-024 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-025 Fetch-to-IF/ID latency: one cycle from an accept edge to id_valid=1.
REQ-026 Throughput: one instruction per cycle with imem_ready=1 and no stall.
REQ-027 imem_addr is stable while imem_ready=0 or stall=1.

Reset
REQ-028 rst_n=0 asynchronously sets:
- state=BOOT;
- PC=RESET_PC;
- imem_req=0;
- id_valid=0 and all IF/ID fields = bubble value.
REQ-029 Reset asserted mid-fetch or mid-stall discards all in-flight state. The first request after reset release is to RESET_PC.

Structure
REQ-030 Shared package mips_pkg holds:
- opcode/funct constants;
- the bubble instruction constant (32'h0);
- the FSM state enum;
- the field bit positions.
REQ-031 Sub-module if_id_reg holds the IF/ID register with hold, clear and load controls. if_stage holds the PC, the FSM and the priority logic.

Verification
REQ-032 Reset, RESET_PC=0, imem_ready=1, sequential memory -> imem_req=0 for one cycle; then imem_addr 0,4,8; id_pc 0,4,8 each one cycle later; id_valid=1 from the 3rd edge.
REQ-033 imem_rdata=32'h8C43_0010 fetched at PC 8 -> next cycle id_opcode=6'b100011, id_rs=2, id_rt=3, id_imm=16'h0010, id_pc_plus4=12.
REQ-034 stall=1 for 3 cycles at PC 0x20 -> imem_addr stays 0x20 and IF/ID is unchanged; after release the fetch resumes at 0x20 with no instruction lost or duplicated.
REQ-035 redirect=1 with redirect_pc=0x103 together with stall=1 -> next cycle PC=0x100, id_valid=0; the following accept gives id_pc=0x100.
REQ-036 imem_ready=0 for 2 cycles, then 1 -> two bubbles (id_valid=0, id_opcode=0); address held; then normal flow.
REQ-037 redirect_pc=0xFFFF_FFFC, two accepts -> id_pc 0xFFFF_FFFC then 0x0000_0000; id_pc_plus4 of the first = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, instruction field positions and fetch-stage types.
// Pure declarations: no logic, no latency, no backpressure.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // All-zero word decodes as sll $0,$0,0: no write, no memory access, no control flow.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with clear (bubble) > hold > load priority.
// One-cycle latency from load to outputs; holds its contents while hold or idle.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm
);

  localparam ifid_t BUBBLE = '{instr: BUBBLE_INSTR, pc: 32'h0, pc_plus4: 32'h0};

  ifid_t data_d, data_q;
  logic  valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      data_d  = BUBBLE;
      valid_d = 1'b0;
    end else if (hold) begin
      data_d  = data_q;
      valid_d = valid_q;
    end else if (load) begin
      data_d  = '{instr: instr, pc: pc, pc_plus4: pc_plus4};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = data_q.pc;
  assign id_pc_plus4 = data_q.pc_plus4;
  assign id_opcode   = data_q.instr[OPCODE_MSB:OPCODE_LSB];
  assign id_rs       = data_q.instr[RS_MSB:RS_LSB];
  assign id_rt       = data_q.instr[RT_MSB:RT_LSB];
  assign id_rd       = data_q.instr[RD_MSB:RD_LSB];
  assign id_funct    = data_q.instr[FUNCT_MSB:FUNCT_LSB];
  assign id_imm      = data_q.instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, boot/run control and redirect > flush > stall > ready priority.
// One instruction per cycle, one-cycle fetch-to-IF/ID latency; stall or !imem_ready holds the PC.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm
);

  if_state_e   state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] pc_plus4;
  logic        run;
  logic        accept;
  logic        ifid_clr;
  logic        ifid_hold;
  logic        unused_rdpc_lo;

  assign run      = (state_q == ST_RUN);
  assign pc_plus4 = pc_q + 32'd4;
  assign unused_rdpc_lo = ^redirect_pc[1:0];

  // Every non-accept RUN cycle that is not a stall leaves a bubble behind.
  assign accept    = run && imem_ready && !stall && !flush && !redirect;
  assign ifid_clr  = run && (redirect || flush || (!stall && !imem_ready));
  assign ifid_hold = run && stall;

  always_comb begin
    state_d = ST_RUN;
    pc_d    = pc_q;
    if (run) begin
      if (redirect) begin
        pc_d = {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req  = run && !stall;
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (ifid_clr),
    .hold        (ifid_hold),
    .load        (accept),
    .instr       (imem_rdata),
    .pc          (pc_q),
    .pc_plus4    (pc_plus4),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_funct    (id_funct),
    .id_imm      (id_imm)
  );

endmodule
